// File: rtl/clock_text_pkg.sv
// Shared constants and helpers for the HH:MM:SS text overlay.
package clock_text_pkg;

   localparam int GLYPH_W   = 8;
   localparam int GLYPH_H   = 16;
   localparam int NUM_CHARS = 8;

   localparam logic [6:0] CHAR_ZERO  = 7'h30;
   localparam logic [6:0] CHAR_COLON = 7'h3A;
   localparam logic [6:0] CHAR_SPACE = 7'h20;

   // ASCII code of a single BCD digit.
   function automatic logic [6:0] digit_code(input logic [3:0] d);
      return CHAR_ZERO + {3'b000, d};
   endfunction

endpackage

// File: rtl/clock_bcd_counter.sv
// Two-digit BCD counter wrapping at {MAX_T, MAX_U}; carry pulses on the wrapping increment.
module clock_bcd_counter #(
   parameter logic [3:0] MAX_T = 4'd5,
   parameter logic [3:0] MAX_U = 4'd9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   output logic       carry,
   output logic [7:0] bcd
);

   logic [3:0] tens;
   logic [3:0] units;
   logic       at_max;

   assign at_max = (tens == MAX_T) && (units == MAX_U);
   // NOTE: carry is combinational so the next field steps on the same edge as this one wraps.
   assign carry  = inc && at_max;
   assign bcd    = {tens, units};

   // NOTE: state is updated with non-blocking assignments only; reset is asynchronous.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tens  <= 4'd0;
         units <= 4'd0;
      end else if (inc) begin
         if (at_max) begin
            tens  <= 4'd0;
            units <= 4'd0;
         end else if (units == 4'd9) begin
            tens  <= tens + 4'd1;
            units <= 4'd0;
         end else begin
            units <= units + 4'd1;
         end
      end
   end

endmodule

// File: rtl/clock_text_gen.sv
// Real-time clock with an 8-character "HH:MM:SS" glyph overlay (2-clk pixel latency).
// Optional: define CLOCK_COLON_BLINK_EN to blink the colons once per second.
module clock_text_gen
   import clock_text_pkg::*;
#(
   parameter logic [9:0] TEXT_X = 10'd288,
   parameter logic [9:0] TEXT_Y = 10'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_1hz,
   input  logic        inc_min,
   input  logic        inc_hour,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        text_on,
   output logic [23:0] time_bcd
);

   logic       sec_carry;
   logic       min_inc;
   logic       min_carry;
   logic       hour_inc;
   logic       unused_hour_carry;
   logic [7:0] hr_bcd;
   logic [7:0] mn_bcd;
   logic [7:0] sc_bcd;

   // Minute wrap reaches the hour only when the seconds rolled it over.
   assign min_inc  = sec_carry | inc_min;
   assign hour_inc = (min_carry & sec_carry) | inc_hour;

   clock_bcd_counter #(.MAX_T(4'd5), .MAX_U(4'd9)) u_sec (
      .clk(clk), .reset(reset), .inc(tick_1hz), .carry(sec_carry), .bcd(sc_bcd)
   );

   clock_bcd_counter #(.MAX_T(4'd5), .MAX_U(4'd9)) u_min (
      .clk(clk), .reset(reset), .inc(min_inc), .carry(min_carry), .bcd(mn_bcd)
   );

   clock_bcd_counter #(.MAX_T(4'd2), .MAX_U(4'd3)) u_hour (
      .clk(clk), .reset(reset), .inc(hour_inc), .carry(unused_hour_carry), .bcd(hr_bcd)
   );

   assign time_bcd = {hr_bcd, mn_bcd, sc_bcd};

   logic [6:0] colon_code;

`ifdef CLOCK_COLON_BLINK_EN
   logic colon_phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         colon_phase <= 1'b1;
      else if (tick_1hz) colon_phase <= ~colon_phase;
   end

   assign colon_code = colon_phase ? CHAR_COLON : CHAR_SPACE;
`else
   assign colon_code = CHAR_COLON;
`endif

   // Field hit test is done at 11 bits so TEXT_X + 64 cannot overflow.
   logic [10:0] x_ext;
   logic [10:0] y_ext;
   logic        in_field;
   logic [5:0]  dx;
   logic [3:0]  dy;
   logic [2:0]  char_idx;
   logic [6:0]  char_code;

   assign x_ext    = {1'b0, x};
   assign y_ext    = {1'b0, y};
   assign in_field = video_on
                   && (x_ext >= {1'b0, TEXT_X})
                   && (x_ext <  ({1'b0, TEXT_X} + 11'(GLYPH_W * NUM_CHARS)))
                   && (y_ext >= {1'b0, TEXT_Y})
                   && (y_ext <  ({1'b0, TEXT_Y} + 11'(GLYPH_H)));
   assign dx       = x[5:0] - TEXT_X[5:0];
   assign dy       = y[3:0] - TEXT_Y[3:0];
   assign char_idx = dx[5:3];

   always_comb begin
      char_code = CHAR_SPACE;
      case (char_idx)
         3'd0:    char_code = digit_code(time_bcd[23:20]);
         3'd1:    char_code = digit_code(time_bcd[19:16]);
         3'd2:    char_code = colon_code;
         3'd3:    char_code = digit_code(time_bcd[15:12]);
         3'd4:    char_code = digit_code(time_bcd[11:8]);
         3'd5:    char_code = colon_code;
         3'd6:    char_code = digit_code(time_bcd[7:4]);
         3'd7:    char_code = digit_code(time_bcd[3:0]);
         default: char_code = CHAR_SPACE;
      endcase
   end

   logic       field_d1;
   logic       field_d2;
   logic [2:0] col_d1;
   logic [2:0] col_d2;

   // Stage 1 issues the ROM read; stage 2 lines the flags up with rom_data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_addr <= {CHAR_SPACE, 4'h0};
         field_d1 <= 1'b0;
         field_d2 <= 1'b0;
         col_d1   <= 3'd0;
         col_d2   <= 3'd0;
      end else begin
         rom_addr <= in_field ? {char_code, dy} : {CHAR_SPACE, 4'h0};
         field_d1 <= in_field;
         col_d1   <= dx[2:0];
         field_d2 <= field_d1;
         col_d2   <= col_d1;
      end
   end

   assign text_on = field_d2 & rom_data[3'd7 - col_d2];

endmodule
